// File: rtl/btc_image_engine.sv
// btc_image_engine
// Grayscale conversion and block-truncation-coding (BTC) compression over an
// image held in an external single-port RAM (1-cycle read latency, shared
// row/col address for reads and writes).
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   start_i            one-cycle request, honoured only while idle
//   mode_i             0 gray, 1 compress, 2/3 gray then compress
//   src_ch_i           compression source byte: 0 B, 1 G, 2 R, 3 G
//   in_pix_i           RAM read data for the previous cycle's address
//   row_o, col_o       RAM address
//   out_we_o, out_pix_o RAM write strobe / data
//   busy_o             engine running
//   gray_done_o        sticky, gray pass finished
//   compress_done_o    sticky, compression pass finished
module btc_image_engine #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int BLK    = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [1:0]        src_ch_i,
  input  logic [23:0]       in_pix_i,
  output logic [ADDR_W-1:0] row_o,
  output logic [ADDR_W-1:0] col_o,
  output logic              out_we_o,
  output logic [23:0]       out_pix_o,
  output logic              busy_o,
  output logic              gray_done_o,
  output logic              compress_done_o
);

  localparam int N  = BLK * BLK;
  localparam int LB = $clog2(BLK);
  localparam int LN = 2 * LB;
  localparam int SW = $clog2(255 * N + 1);
  localparam int CW = LN + 1;            // counts 0..N inclusive

  typedef enum logic [3:0] {
    IDLE, G_RD, G_WR, B_LD, B_AVG, B_DEV, B_LH, B_WR, B_NEXT
  } state_t;

  state_t                   state_q, state_d;
  logic                     gc_q, gc_d;       // gray pass is followed by compress
  logic [1:0]               ch_q, ch_d;       // effective source channel
  logic [ADDR_W-1:0]        prow_q, prow_d, pcol_q, pcol_d;
  logic [ADDR_W-1:0]        brow_q, brow_d, bcol_q, bcol_d;
  logic [CW-1:0]            k_q, k_d;
  logic [SW-1:0]            sum_q, sum_d, dsum_q, dsum_d;
  logic [CW-1:0]            beta_q, beta_d;
  logic [7:0]               avg_q, avg_d, lm_q, lm_d, hm_q, hm_d;
  logic [N-1:0]             bits_q, bits_d;
  logic [N-1:0][7:0]        x_q, x_d;
  logic                     gdone_q, gdone_d, cdone_q, cdone_d;

  function automatic logic [7:0] sel_byte(input logic [23:0] p, input logic [1:0] ch);
    case (ch)
      2'd0:    sel_byte = p[7:0];
      2'd2:    sel_byte = p[23:16];
      default: sel_byte = p[15:8];
    endcase
  endfunction

  // ---------------------------------------------------------------- datapath
  logic [LN-1:0] kidx, kpi;
  logic [7:0]    src_b, xk, mx, mn, y;
  logic          ge;
  logic [7:0]    diff;

  assign kidx  = k_q[LN-1:0];
  assign kpi   = LN'(k_q - CW'(1));     // sample arriving this cycle
  assign src_b = sel_byte(in_pix_i, ch_q);
  assign xk    = x_q[kidx];
  assign ge    = (xk >= avg_q);
  assign diff  = ge ? (xk - avg_q) : (avg_q - xk);

  always_comb begin
    mx = in_pix_i[23:16];
    mn = in_pix_i[23:16];
    if (in_pix_i[15:8] > mx) mx = in_pix_i[15:8];
    if (in_pix_i[7:0]  > mx) mx = in_pix_i[7:0];
    if (in_pix_i[15:8] < mn) mn = in_pix_i[15:8];
    if (in_pix_i[7:0]  < mn) mn = in_pix_i[7:0];
    y = 8'((9'(mx) + 9'(mn)) >> 1);
  end

  // Low/high reconstruction levels. N is a power of two so N*var is just
  // dsum with its low LN bits cleared.
  logic [SW-1:0] nv, den_l, den_h, ql, qh;
  logic [SW:0]   hsum;
  logic [7:0]    lm_w, hm_w;
  logic          all_hi;

  always_comb begin
    nv     = (dsum_q >> LN) << LN;
    all_hi = (beta_q == CW'(N));
    den_l  = SW'({CW'(N) - beta_q, 1'b0});
    den_h  = SW'({beta_q, 1'b0});
    if (all_hi)           den_l = SW'(1);
    if (beta_q == '0)     den_h = SW'(1);
    ql     = nv / den_l;
    qh     = nv / den_h;
    if (all_hi)              lm_w = avg_q;
    else if (ql > SW'(avg_q)) lm_w = 8'd0;
    else                     lm_w = avg_q - ql[7:0];
    hsum   = (SW+1)'(avg_q) + (SW+1)'(qh);
    hm_w   = (hsum > (SW+1)'(255)) ? 8'd255 : hsum[7:0];
  end

  // ------------------------------------------------------------ state regs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gc_q    <= 1'b0;
      ch_q    <= 2'd0;
      prow_q  <= '0;
      pcol_q  <= '0;
      brow_q  <= '0;
      bcol_q  <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      dsum_q  <= '0;
      beta_q  <= '0;
      avg_q   <= '0;
      lm_q    <= '0;
      hm_q    <= '0;
      bits_q  <= '0;
      x_q     <= '0;
      gdone_q <= 1'b0;
      cdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gc_q    <= gc_d;
      ch_q    <= ch_d;
      prow_q  <= prow_d;
      pcol_q  <= pcol_d;
      brow_q  <= brow_d;
      bcol_q  <= bcol_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      dsum_q  <= dsum_d;
      beta_q  <= beta_d;
      avg_q   <= avg_d;
      lm_q    <= lm_d;
      hm_q    <= hm_d;
      bits_q  <= bits_d;
      x_q     <= x_d;
      gdone_q <= gdone_d;
      cdone_q <= cdone_d;
    end
  end

  // ------------------------------------------------------- next state logic
  always_comb begin
    state_d = state_q;
    gc_d    = gc_q;
    ch_d    = ch_q;
    prow_d  = prow_q;
    pcol_d  = pcol_q;
    brow_d  = brow_q;
    bcol_d  = bcol_q;
    k_d     = k_q;
    sum_d   = sum_q;
    dsum_d  = dsum_q;
    beta_d  = beta_q;
    avg_d   = avg_q;
    lm_d    = lm_q;
    hm_d    = hm_q;
    bits_d  = bits_q;
    x_d     = x_q;
    gdone_d = gdone_q;
    cdone_d = cdone_q;

    case (state_q)
      IDLE: if (start_i) begin
        gc_d    = mode_i[1];
        // the gray pass leaves its result in G, so chained mode reads G
        ch_d    = (mode_i == 2'd1) ? src_ch_i : 2'd1;
        gdone_d = 1'b0;
        cdone_d = 1'b0;
        prow_d  = '0;
        pcol_d  = '0;
        brow_d  = '0;
        bcol_d  = '0;
        k_d     = '0;
        sum_d   = '0;
        state_d = (mode_i == 2'd1) ? B_LD : G_RD;
      end
      G_RD: state_d = G_WR;
      G_WR: begin
        if (pcol_q == ADDR_W'(IMG_W - 1)) begin
          pcol_d = '0;
          if (prow_q == ADDR_W'(IMG_H - 1)) begin
            prow_d  = '0;
            gdone_d = 1'b1;
            state_d = gc_q ? B_LD : IDLE;
          end else begin
            prow_d  = prow_q + 1'b1;
            state_d = G_RD;
          end
        end else begin
          pcol_d  = pcol_q + 1'b1;
          state_d = G_RD;
        end
      end
      B_LD: begin
        if (k_q != '0) begin
          x_d[kpi] = src_b;
          sum_d    = sum_q + SW'(src_b);
        end
        if (k_q == CW'(N)) begin
          k_d     = '0;
          state_d = B_AVG;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      B_AVG: begin
        avg_d   = 8'(sum_q >> LN);
        dsum_d  = '0;
        beta_d  = '0;
        state_d = B_DEV;
      end
      B_DEV: begin
        bits_d[kidx] = ge;
        beta_d       = beta_q + CW'(ge);
        dsum_d       = dsum_q + SW'(diff);
        if (k_q == CW'(N - 1)) begin
          k_d     = '0;
          state_d = B_LH;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      B_LH: begin
        lm_d    = lm_w;
        hm_d    = hm_w;
        state_d = B_WR;
      end
      B_WR: begin
        if (k_q == CW'(N - 1)) begin
          k_d     = '0;
          state_d = B_NEXT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      B_NEXT: begin
        sum_d = '0;
        if (bcol_q == ADDR_W'(IMG_W - BLK)) begin
          bcol_d = '0;
          if (brow_q == ADDR_W'(IMG_H - BLK)) begin
            brow_d  = '0;
            cdone_d = 1'b1;
            state_d = IDLE;
          end else begin
            brow_d  = brow_q + ADDR_W'(BLK);
            state_d = B_LD;
          end
        end else begin
          bcol_d  = bcol_q + ADDR_W'(BLK);
          state_d = B_LD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Decoded from reset-cleared state, so a reset forces them low at once.
  always_comb begin
    row_o     = '0;
    col_o     = '0;
    out_we_o  = 1'b0;
    out_pix_o = '0;
    case (state_q)
      G_RD: begin
        row_o = prow_q;
        col_o = pcol_q;
      end
      G_WR: begin
        row_o     = prow_q;
        col_o     = pcol_q;
        out_we_o  = 1'b1;
        out_pix_o = {8'd0, y, 8'd0};
      end
      B_LD: if (k_q != CW'(N)) begin
        row_o = brow_q + ADDR_W'(kidx[LN-1:LB]);
        col_o = bcol_q + ADDR_W'(kidx[LB-1:0]);
      end
      B_WR: begin
        row_o     = brow_q + ADDR_W'(kidx[LN-1:LB]);
        col_o     = bcol_q + ADDR_W'(kidx[LB-1:0]);
        out_we_o  = 1'b1;
        out_pix_o = {8'd0, (bits_q[kidx] ? hm_q : lm_q), 8'd0};
      end
      default: ;
    endcase
  end

  assign busy_o          = (state_q != IDLE);
  assign gray_done_o     = gdone_q;
  assign compress_done_o = cdone_q;

endmodule

// File: tb/tb_btc_image_engine.sv
// Directed bench for btc_image_engine: a 64x64 BLK=4 instance backed by a
// behavioural RAM, plus two 16x8 instances (BLK 2 and 8) for timing/count
// checks.
module tb_btc_image_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  src_ch = 2'd0;
  logic [23:0] in_pix;
  logic [5:0]  row, col;
  logic        we, busy, gd, cd;
  logic [23:0] pix;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  btc_image_engine dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .src_ch_i(src_ch),
    .in_pix_i(in_pix), .row_o(row), .col_o(col), .out_we_o(we), .out_pix_o(pix),
    .busy_o(busy), .gray_done_o(gd), .compress_done_o(cd)
  );

  // Test images: 1 flat 30_80_10; 2 checkerboard 40/200 in G of block 0,
  // G=100 elsewhere, R/B distinct; 3 grey checkerboard in block 0, 30_80_10 elsewhere.
  function automatic logic [23:0] pat(input int id, input int r, input int c);
    logic [7:0] v;
    logic       b0;
    v  = (((r ^ c) & 1) != 0) ? 8'd200 : 8'd40;
    b0 = (r < 4) && (c < 4);
    case (id)
      2:       pat = b0 ? {8'd7, v, 8'd250} : {8'd7, 8'd100, 8'd250};
      3:       pat = b0 ? {v, v, v} : 24'h30_80_10;
      default: pat = 24'h30_80_10;
    endcase
  endfunction

  function automatic logic [23:0] expct(input int id, input int r, input int c);
    logic [7:0] v;
    logic       b0;
    v  = (((r ^ c) & 1) != 0) ? 8'd200 : 8'd40;
    b0 = (r < 4) && (c < 4);
    case (id)
      2:       expct = b0 ? {8'd0, v, 8'd0} : 24'h00_64_00;
      3:       expct = b0 ? {8'd0, v, 8'd0} : 24'h00_48_00;
      default: expct = 24'h00_48_00;
    endcase
  endfunction

  logic [23:0] mem [0:4095];
  logic        ld_req = 1'b0;
  int          ld_id = 0;

  always @(posedge clk) begin
    if (ld_req) begin
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 64; c++)
          mem[r*64+c] <= pat(ld_id, r, c);
    end else if (we) begin
      mem[{row, col}] <= pix;
    end
    in_pix <= mem[{row, col}];
  end

  // sweep instances
  logic        sstart = 1'b0;
  logic [23:0] s2_in, s8_in, s2_pix, s8_pix;
  logic [3:0]  s2_row, s2_col, s8_row, s8_col;
  logic        s2_we, s8_we, s2_busy, s8_busy, s2_gd, s8_gd, s2_cd, s8_cd;
  int          s2_wr, s8_wr;
  logic [3:0]  s2_lr, s2_lc, s8_lr, s8_lc;

  btc_image_engine #(.IMG_W(16), .IMG_H(8), .BLK(2), .ADDR_W(4)) s2 (
    .clk_i(clk), .rst_i(rst), .start_i(sstart), .mode_i(mode), .src_ch_i(src_ch),
    .in_pix_i(s2_in), .row_o(s2_row), .col_o(s2_col), .out_we_o(s2_we), .out_pix_o(s2_pix),
    .busy_o(s2_busy), .gray_done_o(s2_gd), .compress_done_o(s2_cd)
  );
  btc_image_engine #(.IMG_W(16), .IMG_H(8), .BLK(8), .ADDR_W(4)) s8 (
    .clk_i(clk), .rst_i(rst), .start_i(sstart), .mode_i(mode), .src_ch_i(src_ch),
    .in_pix_i(s8_in), .row_o(s8_row), .col_o(s8_col), .out_we_o(s8_we), .out_pix_o(s8_pix),
    .busy_o(s8_busy), .gray_done_o(s8_gd), .compress_done_o(s8_cd)
  );

  always @(posedge clk) begin
    s2_in <= {8'd0, s2_row, s2_col, 8'd0};
    s8_in <= {8'd0, s8_row, s8_col, 8'd0};
    if (sstart) begin
      s2_wr <= 0;
      s8_wr <= 0;
    end else begin
      if (s2_we) begin s2_wr <= s2_wr + 1; s2_lr <= s2_row; s2_lc <= s2_col; end
      if (s8_we) begin s8_wr <= s8_wr + 1; s8_lr <= s8_row; s8_lc <= s8_col; end
    end
  end

  task automatic load(input int id);
    @(negedge clk);
    ld_id  = id;
    ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  // returns #1 after the edge that accepts the start
  task automatic pulse_start(input logic [1:0] m, input logic [1:0] ch);
    @(negedge clk);
    mode   = m;
    src_ch = ch;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit want_c, output int cyc);
    cyc = 0;
    while (cyc < 30000 && !(want_c ? cd : gd)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #1;
    ntotal++; if (we !== 1'b0) $display("FAIL reset_we got %b want 0", we); else npass++;
    ntotal++; if (pix !== 24'd0) $display("FAIL reset_pix got %h want 0", pix); else npass++;
    ntotal++; if ({row, col} !== 12'd0) $display("FAIL reset_addr got %h want 0", {row, col}); else npass++;
    ntotal++; if ({busy, gd, cd} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, gd, cd}); else npass++;
    // start together with reset must not launch anything
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd0;
    @(posedge clk);
    #1;
    ntotal++; if (busy !== 1'b0) $display("FAIL reset_wins busy got %b want 0", busy); else npass++;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_gray();
    int cyc, errs;
    load(1);
    pulse_start(2'd0, 2'd0);
    ntotal++; if ({busy, we, row, col} !== {1'b1, 1'b0, 12'd0}) $display("FAIL gray_first_addr got busy=%b we=%b r=%0d c=%0d want 1 0 0 0", busy, we, row, col); else npass++;
    wait_done(1'b0, cyc);
    ntotal++; if (cyc !== 8192) $display("FAIL gray_cycles got %0d want 8192", cyc); else npass++;
    ntotal++; if ({gd, cd, busy} !== 3'b100) $display("FAIL gray_flags got %b want 100", {gd, cd, busy}); else npass++;
    errs = 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        if (mem[r*64+c] !== expct(1, r, c)) errs++;
    ntotal++; if (errs !== 0) $display("FAIL gray_image got %0d bad words want 0 (word0=%h)", errs, mem[0]); else npass++;
  endtask

  task automatic test_compress();
    int cyc, errs;
    load(2);
    pulse_start(2'd1, 2'd1);
    wait_done(1'b1, cyc);
    ntotal++; if (cyc !== 13312) $display("FAIL comp_cycles got %0d want 13312", cyc); else npass++;
    ntotal++; if ({gd, cd, busy} !== 3'b010) $display("FAIL comp_flags got %b want 010", {gd, cd, busy}); else npass++;
    errs = 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        if (mem[r*64+c] !== expct(2, r, c)) errs++;
    ntotal++; if (errs !== 0) $display("FAIL comp_image got %0d bad words want 0 (w0=%h w1=%h w4=%h)", errs, mem[0], mem[1], mem[4]); else npass++;
  endtask

  task automatic test_reset_mid();
    int cyc, errs;
    load(2);
    pulse_start(2'd1, 2'd1);
    cyc = 0;
    while (cyc < 2000 && !(we && row == 6'd0 && col == 6'd20)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    ntotal++; if (cyc >= 2000) $display("FAIL rstmid_reach got timeout want block5 write"); else npass++;
    rst = 1'b1;
    #1;
    ntotal++; if (we !== 1'b0) $display("FAIL rstmid_we got %b want 0", we); else npass++;
    ntotal++; if ({pix, row, col} !== 36'd0) $display("FAIL rstmid_outs got %h want 0", {pix, row, col}); else npass++;
    ntotal++; if ({busy, gd, cd} !== 3'b000) $display("FAIL rstmid_flags got %b want 000", {busy, gd, cd}); else npass++;
    @(posedge clk);
    #1;
    ntotal++; if (mem[0] !== 24'h00_28_00) $display("FAIL rstmid_kept got %h want 002800", mem[0]); else npass++;
    ntotal++; if (mem[20] !== 24'h07_64_fa) $display("FAIL rstmid_nowrite got %h want 0764fa", mem[20]); else npass++;
    @(negedge clk);
    rst = 1'b0;
    load(2);
    pulse_start(2'd1, 2'd1);
    wait_done(1'b1, cyc);
    ntotal++; if (cyc !== 13312) $display("FAIL rstmid_restart_cycles got %0d want 13312", cyc); else npass++;
    errs = 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        if (mem[r*64+c] !== expct(2, r, c)) errs++;
    ntotal++; if (errs !== 0) $display("FAIL rstmid_image got %0d bad words want 0", errs); else npass++;
  endtask

  task automatic test_mode3_busy_start();
    int cyc, gt, errs;
    load(3);
    pulse_start(2'd3, 2'd0);
    gt  = 0;
    cyc = 0;
    while (cyc < 40000 && !cd) begin
      @(posedge clk);
      #1;
      cyc++;
      start  = (cyc == 100);
      mode   = 2'd1;
      src_ch = 2'd2;
      if (gd && gt == 0) gt = cyc;
    end
    start = 1'b0;
    ntotal++; if (gt !== 8192) $display("FAIL m3_gray_time got %0d want 8192", gt); else npass++;
    ntotal++; if (cyc !== 21504) $display("FAIL m3_comp_time got %0d want 21504", cyc); else npass++;
    ntotal++; if ({gd, cd, busy} !== 3'b110) $display("FAIL m3_flags got %b want 110", {gd, cd, busy}); else npass++;
    errs = 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        if (mem[r*64+c] !== expct(3, r, c)) errs++;
    ntotal++; if (errs !== 0) $display("FAIL m3_image got %0d bad words want 0 (w0=%h w1=%h w4=%h)", errs, mem[0], mem[1], mem[4]); else npass++;
  endtask

  task automatic test_param_sweep();
    int cyc, c2, c8;
    @(negedge clk);
    mode   = 2'd1;
    src_ch = 2'd1;
    sstart = 1'b1;
    @(posedge clk);
    #1;
    sstart = 1'b0;
    c2  = 0;
    c8  = 0;
    cyc = 0;
    while (cyc < 5000 && !(s2_cd && s8_cd)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (s2_cd && c2 == 0) c2 = cyc;
      if (s8_cd && c8 == 0) c8 = cyc;
    end
    ntotal++; if (c2 !== 512) $display("FAIL sweep2_cycles got %0d want 512", c2); else npass++;
    ntotal++; if (c8 !== 392) $display("FAIL sweep8_cycles got %0d want 392", c8); else npass++;
    ntotal++; if (s2_wr / 4 !== 32) $display("FAIL sweep2_blocks got %0d want 32", s2_wr / 4); else npass++;
    ntotal++; if (s8_wr / 64 !== 2) $display("FAIL sweep8_blocks got %0d want 2", s8_wr / 64); else npass++;
    ntotal++; if (s2_wr !== 128) $display("FAIL sweep2_writes got %0d want 128", s2_wr); else npass++;
    ntotal++; if (s8_wr !== 128) $display("FAIL sweep8_writes got %0d want 128", s8_wr); else npass++;
    ntotal++; if ({s2_lr, s2_lc} !== {4'd7, 4'd15}) $display("FAIL sweep2_last got (%0d,%0d) want (7,15)", s2_lr, s2_lc); else npass++;
    ntotal++; if ({s8_lr, s8_lc} !== {4'd7, 4'd15}) $display("FAIL sweep8_last got (%0d,%0d) want (7,15)", s8_lr, s8_lc); else npass++;
  endtask

  initial begin
    test_reset();
    test_gray();
    test_compress();
    test_reset_mid();
    test_mode3_busy_start();
    test_param_sweep();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
